pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush/forward controller for the 5-stage RISC-V pipeline.
- Drives the stall and bubble controls of the IF_ID, ID_EX, EX_ME and ME_WB pipeline registers, and the PC hold.
- Sequences multi-cycle data-memory accesses through a wait-state FSM with timeout.
- Resolves load-use hazards, taken-branch flushes and EX-stage operand forwarding.

---
 rtl/pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward controller for the 5-stage pipeline.
// A memory wait-state FSM (with timeout trap) has the highest priority.
// Taken branches come next, then load-use hazards. EX operand forwarding is
// resolved independently of the stall logic.
// Optional build macro HAZ_PERF_CNT_EN adds stall/flush performance counters.
// Without the macro, stall_cycles and flush_count are tied to 0.
//
// state  | meaning
// S_IDLE | no outstanding multi-cycle data access
// S_WAIT | data access in flight, pipeline frozen until dmem_ack
// S_ERR  | access timed out, pipeline frozen until rst
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic [4:0]  me_rd,
  input  logic        me_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic        ex_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        bubble_id_ex,
  output logic        flush_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_me,
  output logic        bubble_me_wb,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic               mem_stall;
  logic               load_use;

  // ME beats WB: the ME value is the younger result.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    if (m_we && m_rd != 5'd0 && m_rd == rs)      return 2'b10;
    else if (w_we && w_rd != 5'd0 && w_rd == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  // Memory FSM next state, wait counter and same-cycle mem stall request
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    mem_stall  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dmem_req && !dmem_ack) begin
          mem_stall  = 1'b1;
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          state_d = S_IDLE;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            state_d   = S_ERR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      S_ERR: begin
        mem_stall = 1'b1;
        mem_err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, wait counter and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // Prioritised pipeline controls: mem stall > branch flush > load-use stall
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_me  = 1'b0;
    bubble_me_wb = 1'b0;
    fwd_a_sel    = 2'b00;
    fwd_b_sel    = 2'b00;
    if (!rst) begin
      fwd_a_sel = fwd_sel(ex_rs1, me_rd, me_reg_write, wb_rd, wb_reg_write);
      fwd_b_sel = fwd_sel(ex_rs2, me_rd, me_reg_write, wb_rd, wb_reg_write);
      if (mem_stall) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_me  = 1'b1;
        bubble_me_wb = 1'b1;
      end else if (ex_branch_taken) begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end else if (load_use) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Free-running, wrapping event counters
  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, stall_pc};
    flush_count_d  = flush_count_q + {31'd0, flush_if_id};
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
// The driver drives inputs shortly after each rising edge.
// It computes the expected outputs from a behavioural model and queues them.
// The monitor samples on the falling edge and compares against the queue.
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4;

  typedef struct {
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, me_rd, wb_rd;
    logic       ex_mem_read, me_reg_write, wb_reg_write, ex_branch_taken;
    logic       dmem_req, dmem_ack;
  } stim_t;

  typedef struct {
    logic [6:0]  ctrl;
    logic [1:0]  fa, fb;
    logic        err;
    logic [31:0] sc, fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, me_rd, wb_rd;
  logic ex_mem_read, me_reg_write, wb_reg_write, ex_branch_taken, dmem_req, dmem_ack;
  logic stall_pc, stall_if_id, bubble_id_ex, flush_if_id, stall_id_ex, stall_ex_me, bubble_me_wb;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic mem_err;
  logic [31:0] stall_cycles, flush_count;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .me_rd(me_rd), .me_reg_write(me_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id), .stall_id_ex(stall_id_ex), .stall_ex_me(stall_ex_me),
    .bubble_me_wb(bubble_me_wb), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model state: an outstanding access and how many wait cycles it has used
  bit          m_pending = 0;
  int          m_waits   = 0;
  bit          m_err     = 0;
  logic [31:0] m_sc      = 0;
  logic [31:0] m_fc      = 0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
    if (rs == 0) return 2'b00;
    if (s.me_reg_write && s.me_rd == rs) return 2'b10;
    if (s.wb_reg_write && s.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst = 0; s.id_rs1 = 0; s.id_rs2 = 0; s.ex_rs1 = 0; s.ex_rs2 = 0;
    s.ex_rd = 0; s.me_rd = 0; s.wb_rd = 0; s.ex_mem_read = 0; s.me_reg_write = 0;
    s.wb_reg_write = 0; s.ex_branch_taken = 0; s.dmem_req = 0; s.dmem_ack = 0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   frozen, lu;
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1 = s.id_rs1; id_rs2 = s.id_rs2; ex_rs1 = s.ex_rs1;
    ex_rs2 = s.ex_rs2; ex_rd = s.ex_rd; me_rd = s.me_rd; wb_rd = s.wb_rd;
    ex_mem_read = s.ex_mem_read; me_reg_write = s.me_reg_write;
    wb_reg_write = s.wb_reg_write; ex_branch_taken = s.ex_branch_taken;
    dmem_req = s.dmem_req; dmem_ack = s.dmem_ack;

    e.err = m_err;
    e.sc  = m_sc;
    e.fc  = m_fc;
`ifndef HAZ_PERF_CNT_EN
    e.sc = 0;
    e.fc = 0;
`endif
    // Pipeline is frozen while in error, while an access is waiting without ack,
    // or on the first unacked cycle of a new access.
    frozen = m_err || (m_pending && !s.dmem_ack) || (!m_pending && s.dmem_req && !s.dmem_ack);
    lu = s.ex_mem_read && s.ex_rd != 0 && (s.ex_rd == s.id_rs1 || s.ex_rd == s.id_rs2);
    // ctrl = {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, stall_id_ex, stall_ex_me, bubble_me_wb}
    if (s.rst)                  e.ctrl = 7'b0000000;
    else if (frozen)            e.ctrl = 7'b1100111;
    else if (s.ex_branch_taken) e.ctrl = 7'b0011000;
    else if (lu)                e.ctrl = 7'b1110000;
    else                        e.ctrl = 7'b0000000;
    e.fa = s.rst ? 2'b00 : ref_fwd(s.ex_rs1, s);
    e.fb = s.rst ? 2'b00 : ref_fwd(s.ex_rs2, s);
    exp_q.push_back(e);

    // Advance the model across the coming edge
    if (s.rst) begin
      m_pending = 0; m_waits = 0; m_err = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (e.ctrl[6]) m_sc = m_sc + 1;
      if (e.ctrl[3]) m_fc = m_fc + 1;
      if (!m_err) begin
        if (m_pending) begin
          if (s.dmem_ack) m_pending = 0;
          else begin
            m_waits++;
            if (m_waits == TO) begin m_err = 1; m_pending = 0; end
          end
        end else if (s.dmem_req && !s.dmem_ack) begin
          m_pending = 1; m_waits = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare each queued expectation with what the DUT shows mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        chk("ctrl", {25'd0, stall_pc, stall_if_id, bubble_id_ex, flush_if_id,
                     stall_id_ex, stall_ex_me, bubble_me_wb}, {25'd0, e.ctrl});
        chk("fwd_a_sel", {30'd0, fwd_a_sel}, {30'd0, e.fa});
        chk("fwd_b_sel", {30'd0, fwd_b_sel}, {30'd0, e.fb});
        chk("mem_err", {31'd0, mem_err}, {31'd0, e.err});
        chk("stall_cycles", stall_cycles, e.sc);
        chk("flush_count", flush_count, e.fc);
      end
    end
  end

  initial begin
    stim_t s;
    int    guard;
    rst = 1;
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, me_rd, wb_rd} = '0;
    {ex_mem_read, me_reg_write, wb_reg_write, ex_branch_taken, dmem_req, dmem_ack} = '0;

    s = idle_stim(); s.rst = 1;
    apply(s); apply(s);
    s = idle_stim(); apply(s);

    // Load-use on rs2, then same with ex_rd = x0
    s = idle_stim(); s.ex_mem_read = 1; s.ex_rd = 5; s.id_rs2 = 5; apply(s);
    s = idle_stim(); apply(s);
    s = idle_stim(); s.ex_mem_read = 1; s.ex_rd = 0; s.id_rs2 = 0; apply(s);

    // Access acked three cycles after the request
    s = idle_stim(); s.dmem_req = 1; apply(s); apply(s); apply(s);
    s.dmem_ack = 1; apply(s);
    s = idle_stim(); apply(s);

    // Zero-wait access
    s = idle_stim(); s.dmem_req = 1; s.dmem_ack = 1; apply(s);
    s = idle_stim(); apply(s);

    // Branch overrides load-use
    s = idle_stim(); s.ex_branch_taken = 1; s.ex_mem_read = 1; s.ex_rd = 3; s.id_rs1 = 3; apply(s);
    // Branch during a mem stall
    s.dmem_req = 1; apply(s);
    s.dmem_ack = 1; apply(s);

    // Timeout: never acked, stays frozen, then reset
    s = idle_stim(); s.dmem_req = 1;
    for (int i = 0; i < 8; i++) apply(s);
    s.dmem_ack = 1; apply(s);
    s = idle_stim(); s.rst = 1; apply(s);
    s = idle_stim(); apply(s);

    // Forwarding priority
    s = idle_stim(); s.me_rd = 7; s.wb_rd = 7; s.me_reg_write = 1; s.wb_reg_write = 1;
    s.ex_rs1 = 7; s.ex_rs2 = 7; apply(s);
    s.me_reg_write = 0; apply(s);
    s.ex_rs1 = 0; apply(s);
    s.me_rd = 0; s.wb_rd = 0; s.me_reg_write = 1; s.wb_reg_write = 1; s.ex_rs2 = 0; apply(s);

    // Random stimulus with small register numbers for frequent collisions
    for (int i = 0; i < 3000; i++) begin
      s.rst             = ($urandom_range(0, 39) == 0);
      s.id_rs1          = 5'($urandom_range(0, 3));
      s.id_rs2          = 5'($urandom_range(0, 3));
      s.ex_rs1          = 5'($urandom_range(0, 3));
      s.ex_rs2          = 5'($urandom_range(0, 3));
      s.ex_rd           = 5'($urandom_range(0, 3));
      s.me_rd           = 5'($urandom_range(0, 3));
      s.wb_rd           = 5'($urandom_range(0, 3));
      s.ex_mem_read     = 1'($urandom_range(0, 1));
      s.me_reg_write    = 1'($urandom_range(0, 1));
      s.wb_reg_write    = 1'($urandom_range(0, 1));
      s.ex_branch_taken = ($urandom_range(0, 3) == 0);
      s.dmem_req        = 1'($urandom_range(0, 1));
      s.dmem_ack        = ($urandom_range(0, 2) == 0);
      apply(s);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
